// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only cache controller.
// 32 lines x 32-byte blocks (8 x 32-bit words), 16-bit byte addresses. A miss
// refills the whole block word-serially (words 0..7 in order), then returns
// the requested word.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cpu_req, cpu_addr     single-cycle read strobe and byte address (IDLE only)
//   flush                 invalidate-all strobe (IDLE only, wins over cpu_req)
//   cpu_rdata, cpu_ready  read data and one-cycle completion pulse
//   busy                  high whenever the controller is not idle
//   mem_req, mem_addr     refill request and word-aligned refill address
//   mem_rdata, mem_valid  refill data and its per-cycle valid
//   hit_cnt, miss_cnt     saturating hit/miss statistics
module dm_cache_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INDEX_W  = 5,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned Lines  = 1 << INDEX_W;
    localparam int unsigned WSelW  = OFFSET_W - 2;
    localparam int unsigned Words  = 1 << WSelW;
    localparam int unsigned TagW   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WAddrW = ADDR_W - 2;

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StRespond} state_e;

    state_e              state_q, state_d;
    logic [WAddrW-1:0]   addr_q, addr_d;   // word address of the pending request
    logic [WSelW-1:0]    wcnt_q, wcnt_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [Lines-1:0]    valid_q, valid_d;

    // Tag and data storage carry no reset; valid bits guard them.
    logic [TagW-1:0]     tag_arr  [Lines];
    logic [WORD_W-1:0]   data_arr [Lines*Words];

    logic                data_we;
    logic                tag_we;
    logic                hit;

    logic [TagW-1:0]     req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [WSelW-1:0]    req_word;

    // Byte-within-word bits are never used: reads are always full-word.
    logic                unused_byte_sel;
    assign unused_byte_sel = ^cpu_addr[1:0];

    assign req_tag   = addr_q[WAddrW-1 -: TagW];
    assign req_index = addr_q[WSelW +: INDEX_W];
    assign req_word  = addr_q[WSelW-1:0];

    assign hit = valid_q[req_index] && (tag_arr[req_index] == req_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr[ADDR_W-1:2];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    rdata_d = data_arr[{req_index, req_word}];
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d = StRespond;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    wcnt_d  = '0;
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (mem_valid) begin
                    data_we = 1'b1;
                    if (wcnt_q == req_word) rdata_d = mem_rdata;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == '1) begin
                        tag_we             = 1'b1;
                        valid_d[req_index] = 1'b1;
                        state_d            = StRespond;
                    end
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wcnt_q     <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_arr[{req_index, wcnt_q}] <= mem_rdata;
        if (tag_we) tag_arr[req_index] <= req_tag;
    end

    // Decoded from the state register so an asynchronous reset drops mem_req at once.
    assign cpu_rdata = rdata_q;
    assign cpu_ready = (state_q == StRespond);
    assign busy      = (state_q != StIdle);
    assign mem_req   = (state_q == StRefill);
    assign mem_addr  = mem_req ? {req_tag, req_index, wcnt_q, 2'b00} : '0;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
